// File: rtl/execute_stage.sv
// Execute stage: operand forwarding, ALU, and EX/MEM pipeline register.
// Optional iterative shift-add multiplier enabled by defining EXEC_MUL_EN.
module execute_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        IValid,
    input  logic        IRegWrite,
    input  logic        IMemWrite,
    input  logic        IMemRead,
    input  logic        IDataInSelect,
    input  logic [1:0]  IRegStore,
    input  logic [15:0] IPCP2,
    input  logic [15:0] srcA,
    input  logic [15:0] srcB,
    input  logic [15:0] IThirdArg,
    input  logic [2:0]  rdEx,
    input  logic [3:0]  ALUOp,
    input  logic [1:0]  fwdA,
    input  logic [1:0]  fwdB,
    input  logic [15:0] memFwd,
    input  logic [15:0] wbFwd,
    output logic        stall,
    output logic        ORegWrite,
    output logic        MemWrite,
    output logic        MemRead,
    output logic        DataInSelect,
    output logic [1:0]  ORegStore,
    output logic [15:0] OPCP2,
    output logic [15:0] OALUResult,
    output logic [15:0] thirdArg,
    output logic [2:0]  rdMem
);

    localparam logic [3:0] OP_MUL = 4'd10;

    logic [15:0] opA;
    logic [15:0] opB;
    logic [15:0] aluResult;
    logic        loadReal;
    logic [15:0] loadValue;

    always_comb begin
        case (fwdA)
            2'd1:    opA = memFwd;
            2'd2:    opA = wbFwd;
            default: opA = srcA;
        endcase
        case (fwdB)
            2'd1:    opB = memFwd;
            2'd2:    opB = wbFwd;
            default: opB = srcB;
        endcase
    end

    // MUL (10) yields 0 here; the multiplier path supplies its own result.
    always_comb begin
        case (ALUOp)
            4'd0:    aluResult = opA + opB;
            4'd1:    aluResult = opA - opB;
            4'd2:    aluResult = opA & opB;
            4'd3:    aluResult = opA | opB;
            4'd4:    aluResult = opA ^ opB;
            4'd5:    aluResult = opA << opB[3:0];
            4'd6:    aluResult = opA >> opB[3:0];
            4'd7:    aluResult = $signed(opA) >>> opB[3:0];
            4'd8:    aluResult = {15'd0, $signed(opA) < $signed(opB)};
            4'd9:    aluResult = opB;
            default: aluResult = 16'd0;
        endcase
    end

`ifdef EXEC_MUL_EN
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state;
    state_t      nextState;
    logic [15:0] mulA;
    logic [15:0] mulB;
    logic [15:0] mulAcc;
    logic [3:0]  cnt;
    logic        startMul;

    always_comb begin
        nextState = state;
        stall     = 1'b0;
        loadReal  = 1'b0;
        loadValue = aluResult;
        startMul  = 1'b0;
        case (state)
            IDLE: begin
                if (IValid && ALUOp == OP_MUL) begin
                    stall     = 1'b1;
                    startMul  = 1'b1;
                    nextState = RUN;
                end else if (IValid) begin
                    loadReal = 1'b1;
                end
            end
            RUN: begin
                stall = 1'b1;
                if (cnt == 4'd15) nextState = DONE;
            end
            DONE: begin
                loadReal  = 1'b1;
                loadValue = mulAcc;
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
        if (flush) begin
            stall     = 1'b0;
            loadReal  = 1'b0;
            startMul  = 1'b0;
            nextState = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            mulA   <= 16'd0;
            mulB   <= 16'd0;
            mulAcc <= 16'd0;
            cnt    <= 4'd0;
        end else begin
            state <= nextState;
            if (startMul) begin
                mulA   <= opA;
                mulB   <= opB;
                mulAcc <= 16'd0;
                cnt    <= 4'd0;
            end else if (state == RUN && !flush) begin
                // Only the low 16 product bits are kept, so A can shift out freely.
                mulAcc <= mulAcc + (mulB[0] ? mulA : 16'd0);
                mulA   <= mulA << 1;
                mulB   <= mulB >> 1;
                cnt    <= cnt + 4'd1;
            end
        end
    end
`else
    always_comb begin
        stall     = 1'b0;
        loadReal  = IValid && !flush;
        loadValue = aluResult;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset || !loadReal) begin
            ORegWrite    <= 1'b0;
            MemWrite     <= 1'b0;
            MemRead      <= 1'b0;
            DataInSelect <= 1'b0;
            ORegStore    <= 2'd0;
            OPCP2        <= 16'd0;
            OALUResult   <= 16'd0;
            thirdArg     <= 16'd0;
            rdMem        <= 3'd0;
        end else begin
            ORegWrite    <= IRegWrite;
            MemWrite     <= IMemWrite;
            MemRead      <= IMemRead;
            DataInSelect <= IDataInSelect;
            ORegStore    <= IRegStore;
            OPCP2        <= IPCP2;
            OALUResult   <= loadValue;
            thirdArg     <= IThirdArg;
            rdMem        <= rdEx;
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed cases plus randomized ALU
// traffic against an arithmetic reference model; MUL cases follow EXEC_MUL_EN.
module tb_execute_stage;

  localparam int W = 57;

  logic        clk = 1'b0;
  logic        reset, flush, i_valid_d;
  logic        IValid, IRegWrite, IMemWrite, IMemRead, IDataInSelect;
  logic [1:0]  IRegStore;
  logic [15:0] IPCP2, srcA, srcB, IThirdArg, memFwd, wbFwd;
  logic [2:0]  rdEx;
  logic [3:0]  ALUOp;
  logic [1:0]  fwdA, fwdB;
  logic        stall, ORegWrite, MemWrite, MemRead, DataInSelect;
  logic [1:0]  ORegStore;
  logic [15:0] OPCP2, OALUResult, thirdArg;
  logic [2:0]  rdMem;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  execute_stage dut (
    .clk(clk), .reset(reset), .flush(flush), .IValid(IValid),
    .IRegWrite(IRegWrite), .IMemWrite(IMemWrite), .IMemRead(IMemRead),
    .IDataInSelect(IDataInSelect), .IRegStore(IRegStore), .IPCP2(IPCP2),
    .srcA(srcA), .srcB(srcB), .IThirdArg(IThirdArg), .rdEx(rdEx),
    .ALUOp(ALUOp), .fwdA(fwdA), .fwdB(fwdB), .memFwd(memFwd), .wbFwd(wbFwd),
    .stall(stall), .ORegWrite(ORegWrite), .MemWrite(MemWrite),
    .MemRead(MemRead), .DataInSelect(DataInSelect), .ORegStore(ORegStore),
    .OPCP2(OPCP2), .OALUResult(OALUResult), .thirdArg(thirdArg), .rdMem(rdMem)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  // reference model
  function automatic logic [15:0] sel_op(logic [1:0] f, logic [15:0] src);
    if (f == 2'd1) return memFwd;
    if (f == 2'd2) return wbFwd;
    return src;
  endfunction

  function automatic logic [15:0] ref_alu(logic [3:0] op, logic [15:0] a, logic [15:0] b);
    longint ia, ib, sa, sb, d, r;
    ia = a; ib = b;
    sa = (ia >= 32768) ? ia - 65536 : ia;
    sb = (ib >= 32768) ? ib - 65536 : ib;
    d  = longint'(1) << (ib % 16);
    case (op)
      4'd0: r = (ia + ib) % 65536;
      4'd1: r = (ia - ib + 65536) % 65536;
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = (ia * d) % 65536;
      4'd6: r = ia / d;
      4'd7: r = ((sa >= 0) ? sa / d : -((-sa + d - 1) / d)) + 65536;
      4'd8: r = (sa < sb) ? 1 : 0;
      4'd9: r = ib;
`ifdef EXEC_MUL_EN
      4'd10: r = (ia * ib) % 65536;
`endif
      default: r = 0;
    endcase
    r = r % 65536;
    return r[15:0];
  endfunction

  function automatic logic [W-1:0] exp_entry(logic [15:0] res);
    return {IRegWrite, IMemWrite, IMemRead, IDataInSelect, IRegStore, IPCP2,
            res, IThirdArg, rdEx};
  endfunction

  function automatic logic [W-1:0] observed();
    return {ORegWrite, MemWrite, MemRead, DataInSelect, ORegStore, OPCP2,
            OALUResult, thirdArg, rdMem};
  endfunction

  // scoreboard
  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] e);
    checks++;
    assert (obs === e) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, e);
    end
  endtask

  task automatic check_stall(input string tag, input logic e);
    #1;
    check(tag, {{(W-1){1'b0}}, stall}, {{(W-1){1'b0}}, e});
  endtask

  task automatic step(input string tag);
    @(posedge clk); #1;
    if (exp_q.size() == 0) begin
      checks++; failures++;
      $display("FAIL %s expected queue empty", tag);
    end else begin
      check(tag, observed(), exp_q.pop_front());
    end
  endtask

  // driver tasks
  task automatic drive_idle();
    flush = 0; IValid = 0; IRegWrite = 0; IMemWrite = 0; IMemRead = 0;
    IDataInSelect = 0; IRegStore = 0; IPCP2 = 0; srcA = 0; srcB = 0;
    IThirdArg = 0; rdEx = 0; ALUOp = 0; fwdA = 0; fwdB = 0; memFwd = 0; wbFwd = 0;
  endtask

  task automatic drive_random_ctrl();
    IRegWrite = 1'($urandom_range(0, 1)); IMemWrite = 1'($urandom_range(0, 1));
    IMemRead = 1'($urandom_range(0, 1)); IDataInSelect = 1'($urandom_range(0, 1));
    IRegStore = 2'($urandom_range(0, 3)); IPCP2 = 16'($urandom);
    IThirdArg = 16'($urandom); rdEx = 3'($urandom_range(0, 7));
  endtask

  task automatic drive_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    IValid = 1; ALUOp = op; srcA = a; srcB = b; fwdA = 0; fwdB = 0; flush = 0;
  endtask

`ifdef EXEC_MUL_EN
  // Presents a MUL and checks the full 17-bubble stall window plus result.
  task automatic run_mul(input string tag, input logic [15:0] a, input logic [15:0] b);
    drive_random_ctrl();
    drive_op(4'd10, a, b);
    for (int k = 0; k < 17; k++) begin
      check_stall({tag, "_stall_hi"}, 1'b1);
      exp_q.push_back('0);
      step({tag, "_bubble"});
    end
    check_stall({tag, "_stall_lo"}, 1'b0);
    exp_q.push_back(exp_entry(ref_alu(4'd10, a, b)));
    step({tag, "_result"});
  endtask
`endif

  initial begin
    drive_idle();
    // reset with every input non-zero
    reset = 1; flush = 1; IValid = 1; IRegWrite = 1; IMemWrite = 1; IMemRead = 1;
    IDataInSelect = 1; IRegStore = 3; IPCP2 = 16'h1234; srcA = 16'h5555;
    srcB = 16'h0F0F; IThirdArg = 16'hBEEF; rdEx = 3'd6; ALUOp = 4'd3;
    fwdA = 1; fwdB = 2; memFwd = 16'h7777; wbFwd = 16'h3333;
    check_stall("reset_stall", 1'b0);
    exp_q.push_back('0);
    step("reset_outputs");
    reset = 0;
    drive_idle();
    check_stall("post_reset_stall", 1'b0);
    exp_q.push_back('0); step("post_reset_idle0");
    exp_q.push_back('0); step("post_reset_idle1");

    // directed ADD
    drive_idle();
    drive_op(4'd0, 16'h0004, 16'hFFFE);
    IRegWrite = 1; rdEx = 3'd5; IPCP2 = 16'h0011; IThirdArg = 16'hAAAA;
    check_stall("add_stall", 1'b0);
    exp_q.push_back({4'b1000, 2'd0, 16'h0011, 16'h0002, 16'hAAAA, 3'd5});
    step("add_result");

    // forwarding + SLT
    drive_idle();
    drive_op(4'd8, 16'h0000, 16'h0001);
    fwdA = 1; memFwd = 16'h8000;
    exp_q.push_back({4'b0000, 2'd0, 16'h0000, 16'h0001, 16'h0000, 3'd0});
    step("fwd_slt");

    // forwarding + SRA
    drive_idle();
    drive_op(4'd7, 16'h8000, 16'h0000);
    fwdB = 2; wbFwd = 16'h0004;
    exp_q.push_back({4'b0000, 2'd0, 16'h0000, 16'hF800, 16'h0000, 3'd0});
    step("fwd_sra");

    // randomized non-MUL traffic with occasional bubbles and flushes
    for (int i = 0; i < 80; i++) begin
      drive_random_ctrl();
      IValid = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 7) == 0);
      ALUOp = 4'($urandom_range(0, 15));
      if (ALUOp == 4'd10) ALUOp = 4'd9;
      srcA = 16'($urandom); srcB = 16'($urandom);
      memFwd = 16'($urandom); wbFwd = 16'($urandom);
      fwdA = 2'($urandom_range(0, 3)); fwdB = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) srcB = 16'($urandom_range(0, 15));
      i_valid_d = IValid && !flush;
      check_stall("rand_stall", 1'b0);
      exp_q.push_back(i_valid_d ?
        exp_entry(ref_alu(ALUOp, sel_op(fwdA, srcA), sel_op(fwdB, srcB))) : '0);
      step("rand_alu");
    end
    drive_idle();

`ifdef EXEC_MUL_EN
    run_mul("mul_dir", 16'h0123, 16'h0045);
    // back-to-back MULs
    for (int i = 0; i < 3; i++) run_mul("mul_b2b", 16'($urandom), 16'($urandom));
    run_mul("mul_max", 16'hFFFF, 16'hFFFF);

    // flush mid-multiply
    drive_random_ctrl();
    drive_op(4'd10, 16'h0033, 16'h0077);
    for (int k = 0; k < 6; k++) begin
      check_stall("flush_pre_stall", 1'b1);
      exp_q.push_back('0);
      step("flush_pre_bubble");
    end
    flush = 1;
    check_stall("flush_stall", 1'b0);
    exp_q.push_back('0);
    step("flush_bubble");
    drive_random_ctrl();
    drive_op(4'd0, 16'h0007, 16'h0008);
    check_stall("after_flush_stall", 1'b0);
    exp_q.push_back(exp_entry(16'h000F));
    step("after_flush_add");

    // reset mid-multiply
    drive_random_ctrl();
    drive_op(4'd10, 16'h0101, 16'h0202);
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back('0);
      step("rst_mul_bubble");
    end
    reset = 1;
    exp_q.push_back('0);
    step("rst_mul_reset");
    reset = 0;
    drive_random_ctrl();
    drive_op(4'd2, 16'hF0F0, 16'h3C3C);
    check_stall("after_reset_stall", 1'b0);
    exp_q.push_back(exp_entry(16'h3030));
    step("after_reset_and");
`else
    drive_random_ctrl();
    drive_op(4'd10, 16'h0003, 16'h0004);
    check_stall("nomul_stall", 1'b0);
    exp_q.push_back(exp_entry(16'h0000));
    step("nomul_result");
    drive_idle();
    check_stall("nomul_stall_after", 1'b0);
`endif

    drive_idle();
    if (exp_q.size() != 0) begin
      checks++; failures++;
      $display("FAIL leftover_expected count=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
